key_pio_debounced: RTL and testbench



---
 rtl/key_pio_pkg.sv | 18 +
 rtl/key_debounce.sv | 51 +++++
 rtl/key_pio_debounced.sv | 98 +++++++++
 tb/tb_key_pio_debounced.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pio_pkg.sv
// key_pio_pkg: shared constants and helpers for the debounced key PIO.
//   ADDR_*        Avalon word addresses of the register map
//   DATA_W        Avalon data bus width
//   cnt_width()   width of a debounce counter for a given hold time
package key_pio_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE     = 2'd3;

  localparam int DATA_W = 32;

  // Counter only needs to reach cycles-1; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return ($clog2(cycles) < 1) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: one key's 2-flop synchroniser, hold counter and stable flop.
// Ports:
//   clk     system clock
//   reset   asynchronous active-high reset
//   key_in  raw asynchronous key pin
//   stable  debounced level (RESET_LEVEL out of reset)
// A new synchronised level is accepted only after it has been held for
// DEBOUNCE_CYCLES consecutive cycles; any shorter excursion is discarded.
module key_debounce
  import key_pio_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic RESET_LEVEL     = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic key_in,
  output logic stable
);

  localparam int             CW      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1  <= RESET_LEVEL;
      r_sync2  <= RESET_LEVEL;
      r_stable <= RESET_LEVEL;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign stable = r_stable;

endmodule

// File: rtl/key_pio_debounced.sv
// key_pio_debounced: Avalon-MM slave for NUM_KEYS debounced push-buttons.
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   address/read/write    Avalon slave strobes (readLatency = 1)
//   writedata/readdata    32-bit data; readdata is registered every cycle
//   Key_in                raw asynchronous key pins
//   irq                   level interrupt = |(edge_capture & irq_mask)
// Register map: 0 DATA (pressed, RO), 1 reserved, 2 IRQ_MASK (RW),
//   3 EDGE_CAPTURE (write-1-to-clear; a simultaneous press wins).
// Optional feature macro KEY_PIO_IRQ_EN: when undefined there are no mask
//   flops, address 2 reads 0 and irq is tied low.
module key_pio_debounced
  import key_pio_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          address,
  input  logic                read,
  input  logic                write,
  input  logic [DATA_W-1:0]   writedata,
  output logic [DATA_W-1:0]   readdata,
  input  logic [NUM_KEYS-1:0] Key_in,
  output logic                irq
);

  logic [NUM_KEYS-1:0] w_stable;
  logic [NUM_KEYS-1:0] w_pressed;
  logic [NUM_KEYS-1:0] w_press;
  logic [NUM_KEYS-1:0] w_clr;
  logic [NUM_KEYS-1:0] w_mask;
  logic [DATA_W-1:0]   w_rd_mux;
  logic [NUM_KEYS-1:0] r_pressed_d;
  logic [NUM_KEYS-1:0] r_edge;

  // read never gates the mux and upper writedata bits are don't-care
  logic w_unused;
  assign w_unused = read ^ (^writedata);

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_LEVEL     (KEY_ACTIVE_LOW)
    ) u_deb (
      .clk    (clk),
      .reset  (reset),
      .key_in (Key_in[gi]),
      .stable (w_stable[gi])
    );
  end

  // 1 = pressed regardless of board polarity
  assign w_pressed = w_stable ^ {NUM_KEYS{KEY_ACTIVE_LOW}};
  assign w_press   = w_pressed & ~r_pressed_d;
  assign w_clr     = (write && address == ADDR_EDGE) ? writedata[NUM_KEYS-1:0] : '0;

`ifdef KEY_PIO_IRQ_EN
  logic [NUM_KEYS-1:0] r_mask;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_mask <= '0;
    else if (write && address == ADDR_IRQ_MASK) r_mask <= writedata[NUM_KEYS-1:0];
  end

  assign w_mask = r_mask;
  assign irq    = |(r_edge & r_mask);
`else
  assign w_mask = '0;
  assign irq    = 1'b0;
`endif

  always_comb begin
    w_rd_mux = '0;
    case (address)
      ADDR_DATA:     w_rd_mux[NUM_KEYS-1:0] = w_pressed;
      ADDR_IRQ_MASK: w_rd_mux[NUM_KEYS-1:0] = w_mask;
      ADDR_EDGE:     w_rd_mux[NUM_KEYS-1:0] = r_edge;
      default:       w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pressed_d <= '0;
      r_edge      <= '0;
      readdata    <= '0;
    end else begin
      r_pressed_d <= w_pressed;
      // set after clear so a press landing with a W1C write is kept
      r_edge      <= (r_edge & ~w_clr) | w_press;
      readdata    <= w_rd_mux;
    end
  end

endmodule

// File: tb/tb_key_pio_debounced.sv
module tb_key_pio_debounced;

  localparam int D  = 4;
  localparam int NK = 4;
`ifdef KEY_PIO_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    address;
  logic          read;
  logic          write;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [NK-1:0] Key_in;
  logic          irq;

  int checks   = 0;
  int failures = 0;

  key_pio_debounced #(
    .NUM_KEYS        (NK),
    .DEBOUNCE_CYCLES (D),
    .KEY_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .read      (read),
    .write     (write),
    .writedata (writedata),
    .readdata  (readdata),
    .Key_in    (Key_in),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Keeps the raw pin samples seen at each edge. The synchronised value used
  // at an edge is the pin sampled two edges earlier; the debounced level
  // flips once the D most recent such values all disagree with it.
  logic [NK-1:0] m_hist[$];
  logic [NK-1:0] m_stable, m_prs, m_prs_d, m_edge, m_mask, m_clr;
  logic [31:0]   m_rd;
  logic          m_all;
  logic          m_irq;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_stable = '1;
      m_prs_d  = '0;
      m_edge   = '0;
      m_mask   = '0;
      m_rd     = '0;
      m_hist.delete();
    end else begin
      m_prs = ~m_stable;
      case (address)
        2'd0:    m_rd = {28'd0, m_prs};
        2'd2:    m_rd = IRQ_EN ? {28'd0, m_mask} : 32'd0;
        2'd3:    m_rd = {28'd0, m_edge};
        default: m_rd = 32'd0;
      endcase
      m_clr  = (write && address == 2'd3) ? writedata[NK-1:0] : '0;
      m_edge = (m_edge & ~m_clr) | (m_prs & ~m_prs_d);
      m_prs_d = m_prs;
      if (IRQ_EN && write && address == 2'd2) m_mask = writedata[NK-1:0];
      m_hist.push_back(Key_in);
      if (m_hist.size() >= D + 2) begin
        for (int i = 0; i < NK; i++) begin
          m_all = 1'b1;
          for (int j = 0; j < D; j++)
            if (m_hist[m_hist.size() - 3 - j][i] == m_stable[i]) m_all = 1'b0;
          if (m_all) m_stable[i] = ~m_stable[i];
        end
      end
      while (m_hist.size() > D + 2) void'(m_hist.pop_front());
    end
  end

  assign m_irq = IRQ_EN & |(m_edge & m_mask);

  // ---------------- bus helpers ----------------
  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a; read = 1'b1; write = 1'b0;
    @(negedge clk);
    d = readdata;
    read = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; write = 1'b1; writedata = d;
    @(negedge clk);
    write = 1'b0; writedata = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1; Key_in = '1; address = 2'd0; read = 1'b0; write = 1'b0; writedata = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (readdata !== 32'd0) begin failures++; $display("FAIL reset_readdata got=%h exp=%h", readdata, 32'd0); end
    reset = 1'b0;
    repeat (8) @(negedge clk);
    bus_read(2'd0, d);
    checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL idle_data got=%h exp=%h", d, 32'd0); end
    bus_read(2'd3, d);
    checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL idle_edge got=%h exp=%h", d, 32'd0); end
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL idle_irq got=%b exp=0", irq); end
  endtask

  // pressed flips 2+D = 6 edges after the pin change; readdata shows it one edge later
  task automatic test_press_latency();
    logic [31:0] d;
    address = 2'd0;
    Key_in[0] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      checks++;
      if (readdata[0] !== (k >= 7)) begin
        failures++; $display("FAIL press_latency cycle=%0d got=%b exp=%b", k, readdata[0], (k >= 7));
      end
    end
    bus_read(2'd3, d);
    checks++;
    if (d !== 32'h1) begin failures++; $display("FAIL press_edge got=%h exp=%h", d, 32'h1); end
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL press_irq_masked got=%b exp=0", irq); end
    Key_in[0] = 1'b1;
    repeat (8) @(negedge clk);
    bus_read(2'd3, d);
    checks++;
    if (d !== 32'h1) begin failures++; $display("FAIL release_edge got=%h exp=%h", d, 32'h1); end
    bus_read(2'd0, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL release_data got=%h exp=%h", d, 32'h0); end
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    Key_in[1] = 1'b0;
    repeat (D - 1) @(negedge clk);
    Key_in[1] = 1'b1;
    repeat (8) @(negedge clk);
    bus_read(2'd0, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL glitch_data got=%h exp=%h", d, 32'h0); end
    bus_read(2'd3, d);
    checks++;
    if (d !== 32'h1) begin failures++; $display("FAIL glitch_edge got=%h exp=%h", d, 32'h1); end
  endtask

  task automatic test_irq_and_regs();
    logic [31:0] d;
    bus_write(2'd2, 32'h1);
    checks++;
    if (irq !== IRQ_EN) begin failures++; $display("FAIL irq_on_mask got=%b exp=%b", irq, IRQ_EN); end
    bus_read(2'd2, d);
    checks++;
    if (d !== (IRQ_EN ? 32'h1 : 32'h0)) begin failures++; $display("FAIL mask_read got=%h", d); end
    bus_write(2'd3, 32'h1);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL irq_after_w1c got=%b exp=0", irq); end
    bus_read(2'd3, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL edge_after_w1c got=%h exp=%h", d, 32'h0); end
    bus_write(2'd2, 32'hFFFF_FFFF);
    bus_read(2'd2, d);
    checks++;
    if (d !== (IRQ_EN ? 32'hF : 32'h0)) begin failures++; $display("FAIL mask_upper_bits got=%h", d); end
    bus_write(2'd0, 32'hF);
    bus_read(2'd0, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL data_write_ignored got=%h exp=%h", d, 32'h0); end
    bus_write(2'd1, 32'hFFFF_FFFF);
    bus_read(2'd1, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL reserved_read got=%h exp=%h", d, 32'h0); end
  endtask

  // edge bit 2 sets on the 7th edge after the pin change; W1C lands on that edge
  task automatic test_set_wins();
    logic [31:0] d;
    Key_in[2] = 1'b0;
    repeat (6) @(negedge clk);
    bus_write(2'd3, 32'h4);
    bus_read(2'd3, d);
    checks++;
    if (d !== 32'h4) begin failures++; $display("FAIL set_wins_edge got=%h exp=%h", d, 32'h4); end
    checks++;
    if (irq !== IRQ_EN) begin failures++; $display("FAIL set_wins_irq got=%b exp=%b", irq, IRQ_EN); end
    Key_in[2] = 1'b1;
    repeat (8) @(negedge clk);
    bus_write(2'd3, 32'h4);
    bus_read(2'd3, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL set_wins_clear got=%h exp=%h", d, 32'h0); end
  endtask

  task automatic test_reset_mid_count();
    logic [31:0] d;
    address = 2'd0;
    Key_in[3] = 1'b0;
    repeat (4) @(negedge clk);   // two sync edges + counter at 2
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (readdata !== 32'h0) begin failures++; $display("FAIL midreset_data got=%h exp=%h", readdata, 32'h0); end
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL midreset_irq got=%b exp=0", irq); end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if (readdata[3] !== (k >= 7)) begin
        failures++; $display("FAIL midreset_rehold cycle=%0d got=%b exp=%b", k, readdata[3], (k >= 7));
      end
    end
    bus_read(2'd3, d);
    checks++;
    if (d !== 32'h8) begin failures++; $display("FAIL midreset_edge got=%h exp=%h", d, 32'h8); end
    Key_in[3] = 1'b1;
    repeat (8) @(negedge clk);
    bus_write(2'd3, 32'hF);
  endtask

  task automatic test_simultaneous();
    logic [31:0] d;
    Key_in = '0;
    repeat (10) @(negedge clk);
    bus_read(2'd3, d);
    checks++;
    if (d !== 32'hF) begin failures++; $display("FAIL simul_edge got=%h exp=%h", d, 32'hF); end
    bus_read(2'd0, d);
    checks++;
    if (d !== 32'hF) begin failures++; $display("FAIL simul_data got=%h exp=%h", d, 32'hF); end
    Key_in = '1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_random();
    int hold [NK];
    for (int i = 0; i < NK; i++) hold[i] = $urandom_range(1, 9);
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NK; i++) begin
        hold[i]--;
        if (hold[i] == 0) begin
          Key_in[i] = ~Key_in[i];
          hold[i] = $urandom_range(1, 9);
        end
      end
      address   = 2'($urandom_range(0, 3));
      read      = 1'($urandom_range(0, 1));
      write     = ($urandom_range(0, 5) == 0);
      writedata = $urandom;
      @(negedge clk);
      checks++;
      if (readdata !== m_rd) begin
        failures++; $display("FAIL rand_readdata cycle=%0d got=%h exp=%h", c, readdata, m_rd);
      end
      checks++;
      if (irq !== m_irq) begin
        failures++; $display("FAIL rand_irq cycle=%0d got=%b exp=%b", c, irq, m_irq);
      end
    end
    write = 1'b0; read = 1'b0;
  endtask

  initial begin
    test_reset();
    test_press_latency();
    test_glitch();
    test_irq_and_regs();
    test_set_wins();
    test_reset_mid_count();
    test_simultaneous();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
